// File: rtl/dpll_lock_seq.sv
// dpll_lock_seq: reset, settle and lock-check sequencer for a DPLL.
// Each start pulse runs this sequence:
//   reset the DPLL -> settle -> check lock -> (step init_code, settle again)* -> locked / fail
// Optional build macro DPLL_LOCK_SEQ_AUTO_RELOCK_EN: if defined, a lock loss restarts
// the DPLL reset and keeps init_code. If undefined, a lock loss ends in the fail state.
module dpll_lock_seq #(
    parameter int         RST_CYCLES    = 8,
    parameter int         SETTLE_CYCLES = 256,
    parameter int         LOCK_COUNT    = 4,
    parameter int         MAX_RETRY     = 15,
    parameter logic [8:0] INIT_DEFAULT  = 9'd256,
    parameter logic [8:0] STEP          = 9'd16
) (
    input  logic        ref_clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [15:0] target_counter,
    input  logic [15:0] ref_window,
    input  logic [2:0]  status,
    output logic        dpll_resetn,
    output logic [8:0]  init_code,
    output logic [15:0] counter,
    output logic [15:0] ref_counter,
    output logic        busy,
    output logic        locked,
    output logic        fail,
    output logic [3:0]  retry_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRST, S_SETTLE, S_CHECK, S_STEP, S_LOCKED, S_FAIL
    } state_t;

    localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] LOCK_LAST   = 16'(LOCK_COUNT - 1);
    localparam logic [3:0]  RETRY_MAX   = 4'(MAX_RETRY);

    state_t      state, state_nxt;
    logic [2:0]  sync1, sst;
    logic [15:0] cnt;
    logic        loss;      // previous LOCKED cycle already saw sst[0]=0
    logic        started;   // at least one start accepted since reset
    logic        start_ok;
    logic        lost;

    // Move init_code one step against the DCO error, clamped to the 9-bit code range.
    function automatic logic [8:0] step_code(input logic [8:0] code, input logic [2:0] s);
        logic [9:0] sum;
        sum = {1'b0, code} + {1'b0, STEP};
        if (s[1] && !s[2])
            return (code < STEP) ? 9'd0 : code - STEP;
        else if (s[2] && !s[1])
            return sum[9] ? 9'd511 : sum[8:0];
        else
            return code;
    endfunction

    // Two-flop synchronizer for the asynchronous DPLL status bits.
    always_ff @(posedge ref_clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= '0;
            sst   <= '0;
        end else begin
            sync1 <= status;
            sst   <= sync1;
        end
    end

    // State register.
    always_ff @(posedge ref_clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic; an accepted start overrides everything else.
    always_comb begin
        start_ok  = start && (state == S_IDLE || state == S_LOCKED || state == S_FAIL);
        lost      = (state == S_LOCKED) && !sst[0] && loss;
        state_nxt = state;
        if (start_ok) begin
            state_nxt = S_PRST;
        end else begin
            case (state)
                S_PRST:   if (cnt == RST_LAST) state_nxt = S_SETTLE;
                S_SETTLE: if (cnt == SETTLE_LAST) state_nxt = S_CHECK;
                S_CHECK: begin
                    if (!sst[0])               state_nxt = S_STEP;
                    else if (cnt == LOCK_LAST) state_nxt = S_LOCKED;
                end
                S_STEP:   state_nxt = (retry_cnt == RETRY_MAX) ? S_FAIL : S_SETTLE;
                S_LOCKED: begin
`ifdef DPLL_LOCK_SEQ_AUTO_RELOCK_EN
                    if (lost) state_nxt = S_PRST;
`else
                    if (lost) state_nxt = S_FAIL;
`endif
                end
                default:  state_nxt = state;
            endcase
        end
    end

    // Sequence counters, code stepping and latched DPLL configuration words.
    always_ff @(posedge ref_clk or negedge resetn) begin
        if (!resetn) begin
            cnt         <= '0;
            loss        <= 1'b0;
            started     <= 1'b0;
            init_code   <= INIT_DEFAULT;
            retry_cnt   <= '0;
            counter     <= '0;
            ref_counter <= '0;
        end else begin
            // cnt restarts at every state entry and counts cycles spent in the state
            cnt  <= (state_nxt == state) ? cnt + 16'd1 : 16'd0;
            loss <= (state == S_LOCKED) && (state_nxt == S_LOCKED) && !sst[0];
            if (start_ok) begin
                started     <= 1'b1;
                counter     <= target_counter;
                ref_counter <= ref_window;
                init_code   <= INIT_DEFAULT;
                retry_cnt   <= '0;
            end else if (state == S_STEP && retry_cnt != RETRY_MAX) begin
                init_code <= step_code(init_code, sst);
                retry_cnt <= retry_cnt + 4'd1;
            end else if (lost) begin
                // relock keeps the code that last achieved lock
                retry_cnt <= '0;
            end
        end
    end

    // Outputs decoded from state; the DPLL is held in reset until the first start.
    always_comb begin
        busy        = (state == S_PRST) || (state == S_SETTLE) ||
                      (state == S_CHECK) || (state == S_STEP);
        locked      = (state == S_LOCKED);
        fail        = (state == S_FAIL);
        dpll_resetn = !((state == S_PRST) || (state == S_IDLE && !started));
    end

endmodule

// File: tb/tb_dpll_lock_seq.sv
// Testbench for dpll_lock_seq. Two instances share the same stimulus:
//   dut    : default parameters.
//   dut_hi : INIT_DEFAULT = 500, so the upward code saturation at 511 is reached.
// Expected values come from a reference model of the sequence timeline:
//   - a check starts 264 + 258*k cycles after start
//   - saturating step arithmetic for init_code
`timescale 1ns/1ps
module tb_dpll_lock_seq;

    logic        ref_clk;
    logic        resetn;
    logic        start;
    logic [15:0] target_counter;
    logic [15:0] ref_window;
    logic [2:0]  status;

    logic        dpll_resetn, busy, locked, fail;
    logic [8:0]  init_code;
    logic [15:0] counter, ref_counter;
    logic [3:0]  retry_cnt;

    logic        dpll_resetn_hi, busy_hi, locked_hi, fail_hi;
    logic [8:0]  init_code_hi;
    logic [15:0] counter_hi, ref_counter_hi;
    logic [3:0]  retry_cnt_hi;

    int n_tests = 0;
    int n_fail  = 0;
    int ecount  = 0;
    int last_lo = 256;
    int last_hi = 500;
    logic [2:0] sched [16];
    logic [2:0] bad_set [4];
    logic [2:0] good_set [4];

    dpll_lock_seq dut (
        .ref_clk(ref_clk), .resetn(resetn), .start(start),
        .target_counter(target_counter), .ref_window(ref_window), .status(status),
        .dpll_resetn(dpll_resetn), .init_code(init_code), .counter(counter),
        .ref_counter(ref_counter), .busy(busy), .locked(locked), .fail(fail),
        .retry_cnt(retry_cnt)
    );

    dpll_lock_seq #(.INIT_DEFAULT(9'd500)) dut_hi (
        .ref_clk(ref_clk), .resetn(resetn), .start(start),
        .target_counter(target_counter), .ref_window(ref_window), .status(status),
        .dpll_resetn(dpll_resetn_hi), .init_code(init_code_hi), .counter(counter_hi),
        .ref_counter(ref_counter_hi), .busy(busy_hi), .locked(locked_hi), .fail(fail_hi),
        .retry_cnt(retry_cnt_hi)
    );

    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ref_clk);
        #1;
        ecount++;
    endtask

    task automatic tick_to(input int e);
        while (ecount < e) tick();
    endtask

    // Reference step rule: fast DCO lowers the code, slow raises it, clamped to 0..511.
    function automatic int next_code(input int c, input logic [2:0] s);
        if (s[1] && !s[2]) return (c - 16 < 0) ? 0 : c - 16;
        if (s[2] && !s[1]) return (c + 16 > 511) ? 511 : c + 16;
        return c;
    endfunction

    // Run one sequence; sched[k] is the status presented during check k.
    task automatic run_seq(input logic [15:0] tc, input logic [15:0] rw);
        int code_lo;
        int code_hi;
        int retry;
        logic [15:0] junk;
        code_lo = 256;
        code_hi = 500;
        retry   = 0;
        status  = 3'b001;
        target_counter = tc;
        ref_window     = rw;
        start = 1'b1;
        tick();
        start  = 1'b0;
        ecount = 0;
        check_val("start_rstn", dpll_resetn, 0);
        check_val("start_busy", busy, 1);
        check_val("start_init", init_code, 256);
        check_val("start_init_hi", init_code_hi, 500);
        check_val("start_retry", retry_cnt, 0);
        check_val("start_counter", counter, tc);
        check_val("start_refcnt", ref_counter, rw);
        tick_to(7);
        check_val("prst_last_rstn", dpll_resetn, 0);
        tick_to(8);
        check_val("settle_rstn", dpll_resetn, 1);
        // start while busy must be ignored
        tick_to(100);
        junk = 16'($urandom);
        target_counter = junk;
        ref_window     = ~junk;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("ign_counter", counter, tc);
        check_val("ign_refcnt", ref_counter, rw);
        check_val("ign_busy", busy, 1);
        for (int k = 0; k < 16; k++) begin
            int base;
            base = 264 + 258 * k;
            tick_to(base - 100);
            status = sched[k];
            if (sched[k][0]) begin
                tick_to(base + 3);
                check_val("prelock", locked, 0);
                tick_to(base + 4);
                check_val("lock", locked, 1);
                check_val("lock_busy", busy, 0);
                check_val("lock_rstn", dpll_resetn, 1);
                check_val("lock_retry", retry_cnt, retry);
                check_val("lock_init", init_code, code_lo);
                check_val("lock_init_hi", init_code_hi, code_hi);
                check_val("lock_hi", locked_hi, 1);
                last_lo = code_lo;
                last_hi = code_hi;
                break;
            end
            tick_to(base + 2);
            if (retry == 15) begin
                check_val("fail", fail, 1);
                check_val("fail_busy", busy, 0);
                check_val("fail_retry", retry_cnt, 15);
                check_val("fail_init", init_code, code_lo);
                check_val("fail_init_hi", init_code_hi, code_hi);
                break;
            end
            code_lo = next_code(code_lo, sched[k]);
            code_hi = next_code(code_hi, sched[k]);
            retry++;
            check_val("step_retry", retry_cnt, retry);
            check_val("step_init", init_code, code_lo);
            check_val("step_init_hi", init_code_hi, code_hi);
            check_val("step_busy", busy, 1);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_rstn"}, dpll_resetn, 0);
        check_val({tag, "_init"}, init_code, 256);
        check_val({tag, "_init_hi"}, init_code_hi, 500);
        check_val({tag, "_counter"}, counter, 0);
        check_val({tag, "_refcnt"}, ref_counter, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_locked"}, locked, 0);
        check_val({tag, "_fail"}, fail, 0);
        check_val({tag, "_retry"}, retry_cnt, 0);
    endtask

    initial begin
        bad_set  = '{3'b000, 3'b010, 3'b100, 3'b110};
        good_set = '{3'b001, 3'b011, 3'b101, 3'b111};
        resetn = 1'b0;
        start  = 1'b0;
        status = 3'b000;
        target_counter = 16'h0;
        ref_window     = 16'h0;
        #12;
        check_reset_vals("por");
        resetn = 1'b1;
        tick(); tick(); tick();
        check_val("idle_rstn", dpll_resetn, 0);
        check_val("idle_busy", busy, 0);

        // straight lock
        sched[0] = 3'b001;
        run_seq(16'h1234, 16'h0abc);

        // three fast checks then lock: 256 -> 240 -> 224 -> 208
        sched[0] = 3'b010; sched[1] = 3'b010; sched[2] = 3'b010; sched[3] = 3'b001;
        run_seq(16'h4321, 16'h0100);

        // a single-cycle dropout must not count as lock loss
        status = 3'b000;
        tick();
        status = 3'b001;
        tick(); tick(); tick(); tick();
        check_val("glitch_locked", locked, 1);
        check_val("glitch_busy", busy, 0);

        // two-cycle dropout is a lock loss
        status = 3'b000;
        tick(); tick();
        status = 3'b001;
        tick();
        check_val("loss_hold", locked, 1);
        tick();
        ecount = 0;
        check_val("loss_locked", locked, 0);
`ifdef DPLL_LOCK_SEQ_AUTO_RELOCK_EN
        check_val("relock_busy", busy, 1);
        check_val("relock_rstn", dpll_resetn, 0);
        check_val("relock_retry", retry_cnt, 0);
        check_val("relock_init", init_code, last_lo);
        check_val("relock_init_hi", init_code_hi, last_hi);
        tick_to(8);
        check_val("relock_settle_rstn", dpll_resetn, 1);
        tick_to(267);
        check_val("relock_pre", locked, 0);
        tick_to(268);
        check_val("relock_locked", locked, 1);
        check_val("relock_keep_init", init_code, last_lo);
`else
        check_val("loss_fail", fail, 1);
        check_val("loss_busy", busy, 0);
`endif

        // slow DCO held: hi instance saturates at 511, fail after the 16th step
        for (int k = 0; k < 16; k++) sched[k] = 3'b100;
        run_seq(16'h0f0f, 16'hf0f0);

        // randomized sequences
        for (int r = 0; r < 4; r++) begin
            int nbad;
            nbad = $urandom_range(0, 16);
            for (int k = 0; k < 16; k++)
                sched[k] = (k < nbad) ? bad_set[$urandom_range(0, 3)] : good_set[$urandom_range(0, 3)];
            run_seq(16'($urandom), 16'($urandom));
        end

        // asynchronous reset in the middle of CHECK
        sched[0] = 3'b001;
        status = 3'b001;
        start = 1'b1;
        tick();
        start = 1'b0;
        ecount = 0;
        tick_to(266);
        check_val("pre_areset_busy", busy, 1);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_vals("areset");
        #1;
        resetn = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        check_val("post_reset_rstn", dpll_resetn, 0);
        check_val("post_reset_locked", locked, 0);
        check_val("post_reset_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dpll_lock_seq.md
DPLL_LOCK_SEQ -- requirements
Module: dpll_lock_seq

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- RST_CYCLES, 8, ref_clk cycles that dpll_resetn is held low.
- SETTLE_CYCLES, 256, ref_clk cycles waited after a DPLL reset or code step.
- LOCK_COUNT, 4, consecutive lock samples required to declare lock.
- MAX_RETRY, 15, code steps allowed before failing.
- INIT_DEFAULT, 9'd256, first init_code value.
- STEP, 9'd16, init_code adjustment per retry.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- ref_clk, in, 1, the single clock.
- resetn, in, 1, reset, asynchronous, active-low.
- start, in, 1, one-cycle pulse that begins a lock sequence.
- target_counter, in, 16, desired DCO count; forwarded to the DPLL.
- ref_window, in, 16, reference count window; forwarded to the DPLL.
- status, in, 3, DPLL status: [0] lock, [1] DCO fast, [2] DCO slow; asynchronous to ref_clk.
- dpll_resetn, out, 1, active-low reset to the DPLL.
- init_code, out, 9, DPLL initial delay code.
- counter, out, 16, DPLL counter word.
- ref_counter, out, 16, DPLL ref_counter word.
- busy, out, 1, sequence in progress.
- locked, out, 1, lock declared.
- fail, out, 1, retries exhausted.
- retry_cnt, out, 4, steps taken in the current sequence.

Function
REQ-003 status SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value (sst).
REQ-004 FSM states SHALL be IDLE, PRST, SETTLE, CHECK, STEP, LOCKED, FAIL.
REQ-005 IDLE: start=1 SHALL latch target_counter into counter and ref_window into ref_counter, load init_code=INIT_DEFAULT, clear retry_cnt, and go to PRST.
REQ-006 PRST SHALL drive dpll_resetn=0 for exactly RST_CYCLES cycles, then go to SETTLE; dpll_resetn SHALL be 1 in all other states.
REQ-007 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to CHECK.
REQ-008 CHECK SHALL count consecutive cycles with sst[0]=1; on reaching LOCK_COUNT it SHALL go to LOCKED; any cycle with sst[0]=0 SHALL go to STEP.
REQ-009 STEP (one cycle) SHALL apply the following, then go to SETTLE:
- sst[1]=1 and sst[2]=0: init_code-=STEP, saturating at 0.
- sst[2]=1 and sst[1]=0: init_code+=STEP, saturating at 511.
- otherwise: init_code unchanged.
- retry_cnt SHALL increment in every case.
REQ-010 In STEP with retry_cnt==MAX_RETRY before the increment, the FSM SHALL go to FAIL instead, and init_code SHALL hold.
REQ-011 busy=1 in PRST, SETTLE, CHECK and STEP; locked=1 only in LOCKED; fail=1 only in FAIL.
REQ-012 start SHALL be ignored while busy=1; start in LOCKED or FAIL SHALL restart as in REQ-005.
REQ-013 counter and ref_counter SHALL change only on an accepted start.
REQ-014 LOCKED with sst[0]=0 for 2 consecutive cycles SHALL be handled per REQ-019.

Reset
REQ-015 resetn=0 SHALL asynchronously force IDLE with dpll_resetn=0, init_code=INIT_DEFAULT, counter=0, ref_counter=0, busy=0, locked=0, fail=0, retry_cnt=0, and synchronizer flops=0.
REQ-016 After deassertion, dpll_resetn SHALL remain 0 while in IDLE before the first start, and SHALL be 1 in IDLE otherwise.
REQ-017 Reset asserted mid-sequence SHALL abort without completing any pending step.

Configuration
REQ-018 Macro DPLL_LOCK_SEQ_AUTO_RELOCK_EN SHALL select the lock-loss behaviour.
REQ-019 Lock loss (REQ-014):
- Macro defined: clear retry_cnt, keep init_code, go to PRST.
- Macro undefined: go to FAIL.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Scenario 1: start with status=3'b001 held. Required: dpll_resetn low for 8 cycles; locked=1 after 8+256+4+sync cycles; retry_cnt=0; init_code=256.
- Scenario 2: status=3'b010 for 3 checks, then 3'b001. Required: init_code goes 256→240→224→208; retry_cnt=3; then locked=1.
- Scenario 3: status=3'b100 held, INIT_DEFAULT=500. Required: init_code saturates at 511; fail=1 after the 16th STEP; retry_cnt=15.
- Scenario 4: in LOCKED, status drops to 0 for 2 cycles. Required: with macro, PRST entered, retry_cnt=0, init_code kept; without macro, fail=1.
- Scenario 5: start pulsed during SETTLE with new target_counter. Required: start ignored; counter unchanged.
- Scenario 6: resetn low during CHECK. Required: all outputs at REQ-015 values immediately, without waiting for a ref_clk edge.
